// File: rtl/pld_intlv.sv
// Ping-pong 802.11a payload interleaver: a coded symbol is written permuted into one bank while the other bank streams out.
// Optional PLD_INTLV_BYPASS_EN adds a per-symbol bypass_i input that selects the identity mapping.
module pld_intlv #(
  parameter int N_BPSC = 1,
  parameter int SYM_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             di_i,
  input  logic             di_vld_i,
  input  logic [SYM_W-1:0] di_sym_num_i,
`ifdef PLD_INTLV_BYPASS_EN
  input  logic             bypass_i,
`endif
  output logic             di_rdy_o,
  output logic             do_o,
  output logic             do_vld_o,
  input  logic             do_rdy_i,
  output logic [SYM_W-1:0] do_sym_num_o,
  output logic             do_sym_last_o,
  output logic             rd_state_o
);
  localparam int N_CBPS = 48 * N_BPSC;
  localparam int S      = (N_BPSC / 2 > 1) ? N_BPSC / 2 : 1;
  localparam int ROWS   = N_CBPS / 16;
  localparam int AW     = $clog2(N_CBPS);
  localparam int KHW    = $clog2(ROWS);
  localparam logic [AW-1:0]  LAST_ADDR = AW'(N_CBPS - 1);
  localparam logic [KHW-1:0] LAST_KHI  = KHW'(ROWS - 1);

  typedef enum logic {RD_IDLE = 1'b0, RD_READ = 1'b1} rd_state_e;

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
  // do_o/do_sym_num_o/do_sym_last_o hold while do_vld_o is high and do_rdy_i is low.

  logic [3:0]        k_lo_q, k_lo_d;
  logic [KHW-1:0]    k_hi_q, k_hi_d;
  logic              wr_bank_q, wr_bank_d;
  logic [1:0]        full_q, full_d;
  logic [SYM_W-1:0]  tag_q [2];
  logic [N_CBPS-1:0] mem_q [2];
  logic              wr_en, wr_last;
  logic [AW-1:0]     i_w, j_w;
  logic [AW:0]       t_w;
`ifdef PLD_INTLV_BYPASS_EN
  logic              bypass_q;
`endif

  rd_state_e         state_q, state_d;
  logic              rd_bank_q, rd_bank_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic              do_q, do_d, vld_q, vld_d, last_q, last_d;
  logic [SYM_W-1:0]  num_q, num_d;
  logic              fire, last_fire, other_ready, rd_free, load_en, load_bank;
  logic [AW-1:0]     load_addr;

  assign di_rdy_o  = ~(full_q[0] & full_q[1]);
  assign wr_en     = di_vld_i & di_rdy_o;
  assign wr_last   = wr_en && (k_lo_q == 4'hF) && (k_hi_q == LAST_KHI);

  // floor(16i/N_CBPS) is k_lo, so the second permutation step needs no divider
  always_comb begin
    i_w = AW'(ROWS) * AW'(k_lo_q) + AW'(k_hi_q);
    t_w = {1'b0, i_w} + (AW+1)'(N_CBPS) - (AW+1)'(k_lo_q);
    j_w = AW'(S) * (i_w / AW'(S)) + AW'(t_w % (AW+1)'(S));
`ifdef PLD_INTLV_BYPASS_EN
    if (bypass_q) j_w = AW'({k_hi_q, k_lo_q});
`endif
  end

  always_comb begin
    k_lo_d    = k_lo_q;
    k_hi_d    = k_hi_q;
    wr_bank_d = wr_bank_q;
    if (wr_last) begin
      k_lo_d    = '0;
      k_hi_d    = '0;
      wr_bank_d = ~wr_bank_q;
    end else if (wr_en) begin
      k_lo_d = k_lo_q + 4'd1;
      if (k_lo_q == 4'hF) k_hi_d = k_hi_q + KHW'(1);
    end
    full_d = full_q;
    if (rd_free) full_d[rd_bank_q] = 1'b0;
    if (wr_last) full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_bank_q][j_w] <= di_i;
  end

  assign fire        = vld_q & do_rdy_i;
  assign last_fire   = fire & last_q;
  // A symbol finishing on the same cycle lets the reader roll straight into it; address 0 is long written
  assign other_ready = full_q[~rd_bank_q] | (wr_last & (wr_bank_q != rd_bank_q));

  always_comb begin
    state_d = state_q;
    case (state_q)
      RD_IDLE: if (full_q[rd_bank_q]) state_d = RD_READ;
      RD_READ: if (last_fire && !other_ready) state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    load_en   = 1'b0;
    load_bank = rd_bank_q;
    load_addr = rd_addr_q;
    rd_free   = 1'b0;
    rd_bank_d = rd_bank_q;
    rd_addr_d = rd_addr_q;
    do_d      = do_q;
    vld_d     = vld_q;
    num_d     = num_q;
    last_d    = last_q;
    case (state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          load_en   = 1'b1;
          load_addr = '0;
        end
      end
      RD_READ: begin
        if (last_fire) begin
          rd_free   = 1'b1;
          rd_bank_d = ~rd_bank_q;
          rd_addr_d = '0;
          vld_d     = 1'b0;
          last_d    = 1'b0;
          if (other_ready) begin
            load_en   = 1'b1;
            load_bank = ~rd_bank_q;
            load_addr = '0;
          end
        end else if (fire) begin
          load_en = 1'b1;
        end
      end
      default: ;
    endcase
    if (load_en) begin
      do_d      = mem_q[load_bank][load_addr];
      vld_d     = 1'b1;
      num_d     = tag_q[load_bank];
      last_d    = (load_addr == LAST_ADDR);
      rd_addr_d = load_addr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_lo_q    <= '0;
      k_hi_q    <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= '0;
      for (int b = 0; b < 2; b++) tag_q[b] <= '0;
`ifdef PLD_INTLV_BYPASS_EN
      bypass_q  <= 1'b0;
`endif
      state_q   <= RD_IDLE;
      rd_bank_q <= 1'b0;
      rd_addr_q <= '0;
      do_q      <= 1'b0;
      vld_q     <= 1'b0;
      num_q     <= '0;
      last_q    <= 1'b0;
    end else begin
      k_lo_q    <= k_lo_d;
      k_hi_q    <= k_hi_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
      if (wr_en && k_lo_q == 4'd0 && k_hi_q == '0) begin
        tag_q[wr_bank_q] <= di_sym_num_i;
`ifdef PLD_INTLV_BYPASS_EN
        bypass_q <= bypass_i;
`endif
      end
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      rd_addr_q <= rd_addr_d;
      do_q      <= do_d;
      vld_q     <= vld_d;
      num_q     <= num_d;
      last_q    <= last_d;
    end
  end

  assign do_o          = do_q;
  assign do_vld_o      = vld_q;
  assign do_sym_num_o  = num_q;
  assign do_sym_last_o = last_q;
  assign rd_state_o    = state_q;
endmodule

// File: doc/pld_intlv.md
Name: pld_intlv

Overview:
- Payload block interleaver: the stage directly downstream of the channel encoder's puncturing output (serial coded bit + valid + 4-bit symbol number).
- Applies the IEEE 802.11a two-step interleaving permutation per OFDM symbol of N_CBPS coded bits.
- Uses a ping-pong pair of bit buffers: one symbol is written while the previous one is read out serially to the mapper.
- Supports output backpressure and signals input-ready upstream.

Parameters:
- N_BPSC, 1, coded bits per subcarrier (legal: 1, 2, 4, 6); N_CBPS = 48*N_BPSC, s = max(N_BPSC/2, 1).
- SYM_W, 4, width of symbol-number tag.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous reset, active-low.
- di  in  1  coded payload bit.
- di_vld  in  1  di valid; bit accepted when di_vld && di_rdy.
- di_sym_num  in  SYM_W  symbol tag, sampled with the first bit (k=0) of each symbol.
- di_rdy  out  1  a write bank is free.
- do  out  1  interleaved bit.
- do_vld  out  1  do valid.
- do_rdy  in  1  downstream accepts do when do_vld && do_rdy.
- do_sym_num  out  SYM_W  tag of the symbol being read out.
- do_sym_last  out  1  high with the last bit (index N_CBPS-1) of each symbol.

Behaviour:
- Reset (rst=0, asynchronous): both banks empty, write and read pointers 0, write bank 0. Outputs: di_rdy=1, do=0, do_vld=0, do_sym_num=0, do_sym_last=0. Buffer contents are don't-care.
- Write side, input index k = 0..N_CBPS-1, tracked as k_lo = k mod 16 and k_hi = k/16:
  - i = (N_CBPS/16)*k_lo + k_hi
  - j = s*floor(i/s) + ((i + N_CBPS - k_lo) mod s). floor(16i/N_CBPS) equals k_lo, so no divider is needed.
  - Each accepted bit is written to write-bank address j.
  - On the bit with k = N_CBPS-1: mark the bank full, latch its tag, toggle the write bank, reset k to 0.
- di_rdy = 0 only while both banks are full. Bits offered while di_rdy=0 are ignored.
- Read side: state machine IDLE -> READ -> IDLE.
  - IDLE: when the read bank is full, go to READ.
  - READ: addresses 0..N_CBPS-1 are read sequentially. do/do_vld are registered.
  - Latency: first do_vld occurs 2 cycles after the cycle the last bit of a symbol is accepted, provided the read side was idle.
  - do_vld && !do_rdy: do, do_vld, do_sym_num and the read address hold unchanged.
  - Address N_CBPS-1 accepted: assert do_sym_last on that bit, mark the bank empty, toggle the read bank, go to IDLE, or continue directly in READ if the other bank is already full (no bubble).
- Simultaneous events:
  - A bank freed by the read side on cycle T may be written on cycle T+1 (di_rdy rises on T+1).
  - A write completing into the bank the read side is waiting on starts the 2-cycle latency normally.
- Back-to-back symbols: with do_rdy held at 1 and continuous input, throughput is 1 bit/cycle sustained.
- Reset mid-symbol discards all partial and full symbols. No output after reset until a full new symbol is written.
- Storage: 2 x N_CBPS bits (max 576), RAM or registers.

Optional Feature:
- Macro: PLD_INTLV_BYPASS_EN.
- Defined: adds input port bypass (1 bit, sampled at k=0 per symbol, stored with the tag). When the stored bypass is 1, j = k (identity mapping); latency and handshakes are unchanged. Used for bit-exact debug against an uninterleaved reference.
- Undefined: no bypass port; the permutation is always applied.

Test Plan:
- N_BPSC=1, single 1 at k=1, else 0 -> only output index 3 is 1; do_sym_last on index 47; first do_vld exactly 2 cycles after k=47 is accepted.
- N_BPSC=1, 1 at k=16 -> output index 1; 1 at k=47 -> output index 47.
- N_BPSC=4 (N_CBPS=192), 1 at k=1 -> output index 13; 1 at k=0 -> output index 0; random symbol compared bit-exact against the golden model.
- Three back-to-back symbols with tags 5, 6, 7 and do_rdy=1 -> 3*N_CBPS contiguous do_vld cycles, tags 5, 6, 7 in order, no bubbles.
- do_rdy held 0 for 2 symbol times with continuous input -> di_rdy falls after 2 symbols are buffered; release do_rdy -> no bit lost or duplicated.
- rst asserted mid-symbol and mid-readout -> do_vld=0 immediately, di_rdy=1; next full symbol is output correctly with its own tag.
